// File: rtl/uart_tx_device.sv
// rtl/uart_tx_device.sv - memory-mapped 8N1 UART transmitter with byte FIFO (optional parity: UART_TX_PARITY_EN)
module uart_tx_device #(
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        interrupt_request,
    output logic        tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ctrl_enable;
    logic          irq_enable;
`ifdef UART_TX_PARITY_EN
    logic          ctrl_odd;
    logic          parity_bit;
`endif
    logic [15:0]   divisor;
    logic          overflow;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic [1:0]    reg_sel;
    logic          full;
    logic          empty;
    logic          busy;
    logic          data_write;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic [15:0]   bit_reload;
    logic [7:0]    fifo_head;
    logic          unused_bits;

    assign reg_sel     = address[3:2];
    assign full        = (count == DEPTH_COUNT);
    assign empty       = (count == '0);
    assign busy        = (state != S_IDLE);
    assign data_write  = write_enable && (reg_sel == 2'd0);
    // Fullness uses the registered count, so a same-cycle pop never rescues a write.
    assign push        = data_write && !full;
    assign bit_end     = (bit_cnt == 16'd0);
    assign bit_reload  = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign fifo_head   = fifo_mem[rd_ptr];
    assign pop         = ctrl_enable && !empty &&
                         ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign unused_bits = &{1'b0, address[1:0], write_data[31:16]};

    assign interrupt_request = irq_enable && empty && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_enable <= 1'b0;
            irq_enable  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            ctrl_odd    <= 1'b0;
`endif
            divisor     <= DEFAULT_DIVISOR;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (write_enable) begin
                case (reg_sel)
                    2'd1: if (write_data[3]) overflow <= 1'b0;
                    2'd2: begin
                        ctrl_enable <= write_data[0];
                        irq_enable  <= write_data[1];
`ifdef UART_TX_PARITY_EN
                        ctrl_odd    <= write_data[2];
`endif
                    end
                    2'd3: divisor <= write_data[15:0];
                    default: ;
                endcase
            end
            if (data_write && full) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Every bit, including START, reloads the counter so a new DIVISOR lands on a bit boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state      <= S_START;
                        tx         <= 1'b0;
                        bit_cnt    <= bit_reload;
                        shift_reg  <= fifo_head;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_head;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state     <= S_DATA;
                        tx        <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= 3'd0;
                        bit_cnt   <= bit_reload;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= bit_reload;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= parity_bit ^ ctrl_odd;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= bit_reload;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state      <= S_START;
                            tx         <= 1'b0;
                            bit_cnt    <= bit_reload;
                            shift_reg  <= fifo_head;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_head;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        read_data = 32'd0;
        case (reg_sel)
            2'd1: read_data = {16'd0, 8'(count), 4'd0, overflow, empty, full, busy};
            2'd2: begin
                read_data[0] = ctrl_enable;
                read_data[1] = irq_enable;
`ifdef UART_TX_PARITY_EN
                read_data[2] = ctrl_odd;
`endif
            end
            2'd3: read_data = {16'd0, divisor};
            default: read_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_device.sv
// tb/tb_uart_tx_device.sv - directed scoreboard bench for uart_tx_device
module tb_uart_tx_device;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  address = 4'd0;
    logic [31:0] write_data = 32'd0;
    logic        write_enable = 1'b0;
    logic [31:0] read_data;
    logic        interrupt_request;
    logic        tx;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  sb[$];
    int          waited;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    logic        odd_mode = 1'b0;
`else
    localparam int NB = 10;
`endif

    uart_tx_device #(.FIFO_DEPTH(8), .DEFAULT_DIVISOR(16'd434)) dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .write_data        (write_data),
        .write_enable      (write_enable),
        .read_data         (read_data),
        .interrupt_request (interrupt_request),
        .tx                (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        address      = 4'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        address = a;
        #1;
        check(tag, read_data, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (sb.size() < 8) sb.push_back(b);
        bus_write(4'h0, {24'd0, b});
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return (^b) ^ odd_mode;
`endif
        return 1'b1;
    endfunction

    // Finds the START edge (bounded), then checks every cycle of every bit.
    task automatic receive(input int d, input int max_wait, output int w_out);
        logic [7:0] b;
        int w;
        @(negedge clk);
        w = 1;
        while (tx !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        w_out = w;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        b = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < d; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                check($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, j), 32'(tx), 32'(frame_bit(b, k)));
            end
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("reset_tx_low_phase", 32'(tx), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(interrupt_request), 32'd0);
        bus_read(4'hC, 32'h0000_01B2, "reset_divisor");
        bus_read(4'h4, 32'h0000_0004, "reset_status");
        bus_read(4'h8, 32'h0000_0000, "reset_ctrl");
        bus_read(4'h0, 32'h0000_0000, "data_reads_zero");

        // 0x55 at divisor 4, upper divisor bits ignored
        bus_write(4'hC, 32'hFFFF_0004);
        bus_read(4'hC, 32'h0000_0004, "divisor_upper_zero");
        bus_write(4'h8, 32'h0000_0001);
        send_byte(8'h55);
        receive(4, 5, waited);
        check("latency_55", 32'(waited), 32'd2);
        address = 4'h4;
        #1;
        check("busy_in_stop", read_data, 32'h0000_0005);
        @(posedge clk);
        bus_read(4'h4, 32'h0000_0004, "busy_cleared");

        // overflow with enable off, W1C, then gapless drain
        bus_write(4'hC, 32'd2);
        bus_write(4'h8, 32'd0);
        for (int i = 0; i < 9; i++) send_byte(8'(8'h30 + 8'(i * 7)));
        bus_read(4'h4, 32'h0000_080A, "full_overflow");
        bus_write(4'h4, 32'h0000_0000);
        bus_read(4'h4, 32'h0000_080A, "overflow_sticky");
        bus_write(4'h4, 32'h0000_0008);
        bus_read(4'h4, 32'h0000_0802, "overflow_w1c");
        bus_write(4'h8, 32'd1);
        receive(2, 5, waited);
        check("latency_first_of_8", 32'(waited), 32'd2);
        for (int i = 0; i < 7; i++) begin
            receive(2, 1, waited);
        end
        @(posedge clk);
        bus_read(4'h4, 32'h0000_0004, "drained_8");

        // interrupt behaviour
        bus_write(4'hC, 32'd3);
        bus_write(4'h8, 32'd3);
        check("irq_idle_empty", 32'(interrupt_request), 32'd1);
        send_byte(8'hA5);
        check("irq_drop_on_push", 32'(interrupt_request), 32'd0);
        receive(3, 5, waited);
        check("irq_low_in_stop", 32'(interrupt_request), 32'd0);
        @(posedge clk);
        #1;
        check("irq_rise_after_stop", 32'(interrupt_request), 32'd1);
        send_byte(8'h3C);
        check("irq_drop_second", 32'(interrupt_request), 32'd0);
        receive(3, 5, waited);
        bus_write(4'h8, 32'd1);
        check("irq_disabled", 32'(interrupt_request), 32'd0);

        // divisor 0 behaves as 1
        bus_write(4'hC, 32'd0);
        bus_read(4'hC, 32'd0, "divisor_zero_read");
        send_byte(8'hFF);
        receive(1, 5, waited);
        check("latency_div0", 32'(waited), 32'd2);
        @(posedge clk);

        // reset during DATA
        bus_write(4'hC, 32'd4);
        send_byte(8'h07);
        send_byte(8'h11);
        repeat (17) @(negedge clk);
        check("pre_reset_data_bit", 32'(tx), 32'd0);
        #1;
        reset = 1'b0;
        address = 4'h4;
        #1;
        check("reset_tx_async", 32'(tx), 32'd1);
        check("reset_status_mid", read_data, 32'h0000_0004);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("tx_idle_after_reset", 32'(tx), 32'd1);
        bus_read(4'h4, 32'h0000_0004, "fifo_discarded");
        bus_read(4'hC, 32'h0000_01B2, "divisor_after_reset");

        // 0x07 frame (parity bit 1 when parity built in)
        bus_write(4'hC, 32'd2);
        bus_write(4'h8, 32'd1);
        send_byte(8'h07);
        receive(2, 5, waited);
        check("latency_07", 32'(waited), 32'd2);
`ifdef UART_TX_PARITY_EN
        @(posedge clk);
        bus_write(4'h8, 32'd5);
        odd_mode = 1'b1;
        send_byte(8'h07);
        receive(2, 5, waited);
        odd_mode = 1'b0;
`endif
        @(posedge clk);
        bus_write(4'h8, 32'd7);
`ifdef UART_TX_PARITY_EN
        bus_read(4'h8, 32'h0000_0007, "ctrl_bit2");
`else
        bus_read(4'h8, 32'h0000_0003, "ctrl_bit2");
`endif
        check("irq_final", 32'(interrupt_request), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_device.md
# uart_tx_device

Memory-mapped UART transmitter peripheral that hangs off the system bridge beside the two timer devices. It accepts register writes and reads through the same word-addressed device port style the bridge already drives, and buffers bytes in a small FIFO. It serialises them on a single `tx` line (8N1) and raises a level interrupt request toward the bridge's interrupt vector when the transmitter drains.

## Interface
- `FIFO_DEPTH`, 8, byte FIFO entries; power of two, minimum 2.
- `DEFAULT_DIVISOR`, 16'd434, reset value of DIVISOR, in clock cycles per bit.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset: asserting (0) clears all state immediately; release is synchronous to `clk`.
- `address`  input  4  byte offset inside the device window; bits [3:2] select a register, bits [1:0] are ignored.
- `write_data`  input  32  write payload.
- `write_enable`  input  1  one-cycle write strobe from the bridge.
- `read_data`  output  32  combinational read of the register selected by `address`.
- `interrupt_request`  output  1  level IRQ to the bridge.
- `tx`  output  1  serial line; idle high.

## Operation
- Register map (word offset):
  - 0x0 DATA: a write pushes `write_data[7:0]`; reads return 0.
  - 0x4 STATUS, read-only except bit 3:
    - bit 0 busy: FSM not IDLE.
    - bit 1 full.
    - bit 2 empty.
    - bit 3 overflow, sticky; writing 1 to bit 3 clears it (W1C).
    - bits [15:8] FIFO count.
  - 0x8 CTRL: bit 0 enable, bit 1 irq_enable; other bits read 0.
  - 0xC DIVISOR: bits [15:0]; upper bits read 0.
- Push:
  - A write to DATA when count == FIFO_DEPTH is dropped and sets overflow.
  - Fullness is judged on the registered count. A pop in the same cycle does not rescue the write.
- FSM states: IDLE → START → DATA → STOP → IDLE, or STOP → START directly when the FIFO is non-empty and enable = 1.
  - IDLE: when enable = 1 and the FIFO is non-empty, pop the head into the shift register and go to START.
  - START drives 0. DATA drives 8 bits LSB-first. STOP drives 1.
- Bit counter:
  - Loads max(DIVISOR,1) − 1 at each bit start and decrements to 0, so every bit lasts max(DIVISOR,1) cycles.
  - DIVISOR = 0 behaves as 1.
  - The counter is 16 bits wide and never wraps below 0.
- DIVISOR written mid-frame takes effect at the next bit boundary.
- Clearing enable mid-frame finishes the current frame, then the FSM holds in IDLE and the FIFO is retained.
- FIFO:
  - Circular, with read and write pointers of log2(FIFO_DEPTH) bits that wrap naturally.
  - Count is a separate log2(FIFO_DEPTH)+1 bit register.
  - A push and a pop in the same cycle leave count unchanged.
- `interrupt_request` = irq_enable & empty & (state == IDLE). It is combinational from registered state and stays high until a byte is pushed or irq_enable is cleared.

## Timing
- Reset values:
  - `tx` = 1; state IDLE; FIFO empty; CTRL = 0; overflow = 0; DIVISOR = DEFAULT_DIVISOR.
  - `interrupt_request` = 0.
  - `read_data` follows `address` combinationally, e.g. 0x0000_0004 at offset 0x4 with the FIFO empty.
- Write at rising edge T (FIFO empty, idle, enabled):
  - Count is 1 after T.
  - Pop at edge T+1, when `tx` falls to 0 (START).
  - First data bit at T+1+D, where D = max(DIVISOR,1).
  - STOP begins at T+1+9D; the line is free at T+1+10D.
- Back-to-back bytes have no idle gap: the next START begins at the edge ending STOP.
- `tx` is driven from a flop, so it never glitches.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously and the FIFO contents are discarded.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits). Frames are 11 bits and STOP begins at T+1+10D. CTRL bit 2 is writable and selects odd parity when 1.
  - Undefined: 8N1 only; CTRL bit 2 reads 0.

## Test plan
- Reset release → `tx` = 1, DIVISOR reads 0x0000_01B2, STATUS reads 0x0000_0004, `interrupt_request` = 0.
- DIVISOR = 4, CTRL = 1, write DATA 0x55 → `tx` shows 0 for 4 cycles starting one cycle after the write, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1; busy clears after 40 cycles.
- DIVISOR = 2, CTRL = 0, write 9 bytes with FIFO_DEPTH = 8 → STATUS reads count 8, full = 1, overflow = 1; W1C to bit 3 clears overflow; CTRL = 1 then transmits exactly the first 8 bytes with no gaps.
- CTRL = 3, send one byte with DIVISOR = 3 → `interrupt_request` rises the cycle after STOP ends (30 cycles after the pop); a write to DATA drops it the next cycle.
- DIVISOR = 0 with byte 0xFF → every bit lasts 1 cycle: frame is 0 followed by nine 1s.
- Reset pulsed low mid-DATA → `tx` = 1 immediately, STATUS = 0x0000_0004; with `UART_TX_PARITY_EN` defined, byte 0x07 yields parity bit 1.
